// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a byte stream (16-bit word count, then
// big-endian 32-bit words), writes words at consecutive addresses, and holds the core until done.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SHIFT_W = 24;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_WORD, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    word_idx_q, word_idx_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  logic [CNT_W-1:0]    len_full;
  logic [CNT_W-1:0]    word_next;
  logic [31:0]         word_full;

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state and state-decoded outputs; write address/data are captured on the 4th byte
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    byte_ready  = 1'b0;
    mem_we      = 1'b0;
    cpu_hold    = 1'b1;
    done        = 1'b0;
    error       = 1'b0;

    len_full  = {count_q[15:8], byte_in};
    word_next = word_idx_q + CNT_W'(1);
    word_full = {shift_q, byte_in};

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          count_d = {byte_in, count_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          count_d = len_full;
          if (len_full == '0) begin
            state_d = S_DONE;
          end else if (32'(len_full) > DEPTH_WORDS) begin
            state_d = S_ERR;
          end else begin
            word_idx_d = '0;
            byte_cnt_d = '0;
            state_d    = S_WORD;
          end
        end
      end
      S_WORD: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          shift_d    = word_full[SHIFT_W-1:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_wdata_d = word_full;
            mem_addr_d  = ADDR_W'({word_idx_q, 2'b00});
            state_d     = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        mem_we     = 1'b1;
        word_idx_d = word_next;
        if (word_next == count_q) begin
          state_d = S_DONE;
        end else begin
          byte_cnt_d = '0;
          state_d    = S_WORD;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_d = S_LEN_HI;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_d = S_LEN_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a negedge monitor checks them.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] prog[$];
  int          checks   = 0;
  int          failures = 0;
  int          writes   = 0;
  int          accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && byte_valid === 1'b1 && byte_ready === 1'b1) accepted++;
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e.addr);
        chk("write_data", mem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    bit ok;
    int n;
    byte_in    = b;
    byte_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
    byte_valid = 1'b0;
    if (gappy) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("ready_after_start", 32'(byte_ready), 32'd1);
    chk("done_after_start", 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  // Sends count + prog words; checks write-cycle and done latency after the last byte
  task automatic load(input bit gappy, input bit hold_start);
    int n;
    int w0;
    n  = prog.size();
    w0 = writes;
    accepted = 0;
    send_byte(8'(n >> 8), gappy);
    send_byte(8'(n), gappy);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.addr = 32'(i * 4);
      e.data = prog[i];
      exp_q.push_back(e);
      start = hold_start && (i < n - 1);
      for (int k = 3; k >= 0; k--) send_byte(8'(prog[i] >> (8 * k)), gappy);
    end
    start = 1'b0;
    if (!gappy) begin
      @(negedge clk);
      chk("last_write_we", 32'(mem_we), 32'd1);
      chk("done_during_write", 32'(done), 32'd0);
    end else begin
      @(negedge clk);
    end
    @(negedge clk);
    chk("done_after_load", 32'(done), 32'd1);
    chk("cpu_hold_after_load", 32'(cpu_hold), 32'd0);
    chk("ready_in_done", 32'(byte_ready), 32'd0);
    chk("write_count", 32'(writes - w0), 32'(n));
    chk("bytes_accepted", 32'(accepted), 32'(2 + 4 * n));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    start = 1'b0; byte_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal load, continuous valid
    prog = '{32'h2401_0005, 32'h8C02_0004};
    pulse_start();
    load(1'b0, 1'b0);

    // Gappy source
    pulse_start();
    load(1'b1, 1'b0);

    // Zero count
    pulse_start();
    accepted = 0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_hold", 32'(cpu_hold), 32'd0);
    @(posedge clk); #1;
    pulse_start();

    // Over capacity (already in LEN_HI)
    send_byte(8'h00, 1'b0);
    send_byte(8'h41, 1'b0);
    @(negedge clk);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_hold", 32'(cpu_hold), 32'd1);
    chk("ovf_ready", 32'(byte_ready), 32'd0);
    chk("ovf_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk("ovf_error_held", 32'(error), 32'd1);
    @(posedge clk); #1;
    prog = '{32'hDEAD_BEEF};
    pulse_start();
    chk("error_cleared", 32'(error), 32'd0);
    load(1'b0, 1'b0);

    // Reset after 2 bytes of the first word
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h24, 1'b0);
    send_byte(8'h01, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(byte_ready), 32'd0);
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    prog = '{32'h2401_0005, 32'h8C02_0004};
    pulse_start();
    load(1'b0, 1'b0);

    // start held high while busy
    prog = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    pulse_start();
    load(1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
